// File: rtl/axis_arb_mux.sv
// axis_arb_mux: round-robin packet arbiter merging NUM_PORTS AXI-Stream slaves onto one master.
// A grant is held for a whole packet, from the first beat until the beat that carries tlast.
// Build option: define AXIS_ARB_MUX_OUT_REG_EN to drive m_* from a 2-entry skid register.
// Without it, m_* is a combinational pass-through of the granted port.
module axis_arb_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_PORTS-1:0]              s_tvalid,
    output logic [NUM_PORTS-1:0]              s_tready,
    input  logic [NUM_PORTS-1:0]              s_tlast,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic [DATA_WIDTH/8-1:0]           m_tkeep,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic                              m_tlast,
    output logic [ID_WIDTH-1:0]               m_tid,
    output logic [NUM_PORTS-1:0]              grant
);

    localparam int KeepW = DATA_WIDTH / 8;
    localparam int IdxW  = $clog2(NUM_PORTS);

    typedef enum logic {StIdle, StActive} state_e;

    state_e                state_q, state_d;
    logic [NUM_PORTS-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic [IdxW-1:0]       win_idx;
    logic                  win_found;
    logic                  active;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KeepW-1:0]      sel_keep;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  out_ready;
    logic                  beat;

    assign active   = (state_q == StActive);
    assign grant    = grant_q;
    assign s_tready = (active && out_ready) ? grant_q : '0;
    assign beat     = active && sel_valid && out_ready;

    // Select the granted port's fields.
    always_comb begin
        sel_data  = s_tdata[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_tkeep[int'(idx_q)*KeepW +: KeepW];
        sel_valid = s_tvalid[idx_q];
        sel_last  = s_tlast[idx_q];
    end

    // Round-robin search starting one past the previous winner, wrapping upward.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(last_q) + k) % NUM_PORTS;
            if (!win_found && s_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(cand);
            end
        end
    end

    // Next-state: arbitrate in idle, release the lock after the tlast beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StActive;
                    grant_d = NUM_PORTS'(1) << win_idx;
                    idx_d   = win_idx;
                    last_d  = win_idx;
                end
            end
            StActive: begin
                if (beat && sel_last) begin
                    state_d = StIdle;
                    grant_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Arbiter state; last_q resets so that port 0 wins first.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= StIdle;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IdxW'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

`ifdef AXIS_ARB_MUX_OUT_REG_EN
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [KeepW-1:0]      buf_keep_q [2];
    logic [ID_WIDTH-1:0]   buf_id_q   [2];
    logic [1:0]            buf_last_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  pop;

    // Ready comes from occupancy only, so s_tready never sees m_tready combinationally.
    assign out_ready = (count_q != 2'd2);
    assign pop       = (count_q != 2'd0) && m_tready;

    // Skid buffer: push accepted beats, pop on the downstream handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_keep_q[i] <= '0;
                buf_id_q[i]   <= '0;
            end
            buf_last_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (beat) begin
                buf_data_q[wr_ptr_q] <= sel_data;
                buf_keep_q[wr_ptr_q] <= sel_keep;
                buf_id_q[wr_ptr_q]   <= ID_WIDTH'(idx_q);
                buf_last_q[wr_ptr_q] <= sel_last;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, beat} - {1'b0, pop};
        end
    end

    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = buf_data_q[rd_ptr_q];
    assign m_tkeep  = buf_keep_q[rd_ptr_q];
    assign m_tlast  = buf_last_q[rd_ptr_q];
    assign m_tid    = buf_id_q[rd_ptr_q];
`else
    assign out_ready = m_tready;
    assign m_tvalid  = active && sel_valid;
    assign m_tdata   = active ? sel_data : '0;
    assign m_tkeep   = active ? sel_keep : '0;
    assign m_tlast   = active && sel_last;
    assign m_tid     = active ? ID_WIDTH'(idx_q) : '0;
`endif

endmodule

// File: tb/tb_axis_arb_mux.sv
// tb_axis_arb_mux: directed and random stimulus with a per-port scoreboard for axis_arb_mux.
// Works with or without AXIS_ARB_MUX_OUT_REG_EN; checks are latency-independent where needed.
module tb_axis_arb_mux;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       l;
    } beat_t;

    logic        aclk;
    logic        areset;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tready;
    logic [3:0]  s_tlast;
    logic [7:0]  m_tdata;
    logic [0:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [1:0]  m_tid;
    logic [3:0]  grant;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    beat_t      src_q [4][$];
    beat_t      exp_q [4][$];
    logic [3:0] hold;
    int         pkt_log [$];
    int         pkt_cyc [$];
    logic [7:0] out_log [$];

    axis_arb_mux #(
        .DATA_WIDTH(8),
        .NUM_PORTS (4)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .s_tdata (s_tdata),
        .s_tkeep (s_tkeep),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tlast (s_tlast),
        .m_tdata (m_tdata),
        .m_tkeep (m_tkeep),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast (m_tlast),
        .m_tid   (m_tid),
        .grant   (grant)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Drive each port from the head of its source queue.
    task automatic refresh_src();
        for (int p = 0; p < 4; p++) begin
            if (src_q[p].size() != 0 && !hold[p]) begin
                s_tvalid[p]       = 1'b1;
                s_tdata[p*8 +: 8] = src_q[p][0].d;
                s_tkeep[p]        = src_q[p][0].k;
                s_tlast[p]        = src_q[p][0].l;
            end else begin
                s_tvalid[p]       = 1'b0;
                s_tdata[p*8 +: 8] = 8'h00;
                s_tkeep[p]        = 1'b0;
                s_tlast[p]        = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes mid-cycle, retire accepted beats after the edge.
    task automatic tick();
        logic [3:0] acc;
        logic       rs;
        @(negedge aclk);
        acc = s_tvalid & s_tready;
        rs  = areset;
        @(posedge aclk);
        #1;
        if (!rs) begin
            for (int p = 0; p < 4; p++) begin
                if (acc[p]) void'(src_q[p].pop_front());
            end
        end
        refresh_src();
        #1;
    endtask

    task automatic push_pkt(input int p, input int len, input logic [7:0] d0, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = rnd ? 8'($urandom) : d0 + 8'(i);
            b.k = rnd ? 1'($urandom) : 1'b1;
            b.l = (i == len - 1);
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
        refresh_src();
    endtask

    function automatic bit all_empty();
        for (int p = 0; p < 4; p++) begin
            if (src_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic do_reset();
        areset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        hold = '0;
        refresh_src();
        tick();
        tick();
        areset = 1'b0;
        pkt_log.delete();
        pkt_cyc.delete();
        out_log.delete();
    endtask

    task automatic drain(input string tag, input bit rnd);
        int n;
        n = 0;
        while (!all_empty() && n < 4000) begin
            if (rnd) m_tready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        m_tready = 1'b1;
        check({tag, "_drained"}, 32'(all_empty()), 1);
    endtask

    // Output monitor: every downstream handshake is scored against the source port's queue.
    initial begin
        beat_t b;
        bit    in_pkt;
        int    cur_tid;
        in_pkt  = 1'b0;
        cur_tid = 0;
        forever begin
            @(negedge aclk);
            cyc++;
            if (areset) begin
                in_pkt = 1'b0;
            end else if (m_tvalid && m_tready) begin
                check("beat_expected", 32'(exp_q[m_tid].size() != 0), 1);
                if (exp_q[m_tid].size() != 0) begin
                    b = exp_q[m_tid].pop_front();
                    check("m_tdata", m_tdata, b.d);
                    check("m_tkeep", m_tkeep, b.k);
                    check("m_tlast", m_tlast, b.l);
                end
                if (in_pkt) begin
                    check("tid_contiguous", m_tid, cur_tid);
                end else begin
                    pkt_log.push_back(int'(m_tid));
                    pkt_cyc.push_back(cyc);
                    cur_tid = int'(m_tid);
                    in_pkt  = 1'b1;
                end
                out_log.push_back(m_tdata);
                if (m_tlast) in_pkt = 1'b0;
            end
        end
    end

    initial begin
        logic [5:0] pat;
        areset   = 1'b1;
        m_tready = 1'b1;
        hold     = '0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;

        // Reset values.
        do_reset();
        check("rst_grant", grant, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tkeep", m_tkeep, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tid", m_tid, 0);

        // Single 3-beat packet from port 2.
        push_pkt(2, 3, 8'h21, 1'b0);
        check("p2_grant_before", grant, 4'b0000);
        tick();
        check("p2_grant", grant, 4'b0100);
        tick();
        tick();
        check("p2_grant_locked", grant, 4'b0100);
        tick();
        check("p2_idle_after", grant, 4'b0000);
        drain("p2", 1'b0);
        check("p2_pkts", pkt_log.size(), 1);
        if (pkt_log.size() == 1) check("p2_tid", pkt_log[0], 2);

        // All ports, 2-beat packets back-to-back: order 0,1,2,3,0 at 3 cycles each.
        do_reset();
        push_pkt(0, 2, 8'h01, 1'b0);
        push_pkt(0, 2, 8'h05, 1'b0);
        push_pkt(1, 2, 8'h11, 1'b0);
        push_pkt(2, 2, 8'h21, 1'b0);
        push_pkt(3, 2, 8'h31, 1'b0);
        drain("rr", 1'b0);
        check("rr_pkts", pkt_log.size(), 5);
        if (pkt_log.size() == 5) begin
            check("rr_order0", pkt_log[0], 0);
            check("rr_order1", pkt_log[1], 1);
            check("rr_order2", pkt_log[2], 2);
            check("rr_order3", pkt_log[3], 3);
            check("rr_order4", pkt_log[4], 0);
            for (int i = 1; i < 5; i++) check("rr_spacing", pkt_cyc[i] - pkt_cyc[i-1], 3);
        end

        // Port 1 stalls mid-packet while port 3 waits; the lock must hold.
        do_reset();
        push_pkt(1, 4, 8'h11, 1'b0);
        tick();
        check("lock_grant", grant, 4'b0010);
        tick();
        hold[1] = 1'b1;
        refresh_src();
        push_pkt(3, 2, 8'h31, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("lock_hold_grant", grant, 4'b0010);
            check("lock_p3_ready", s_tready[3], 0);
        end
        hold[1] = 1'b0;
        refresh_src();
        drain("lock", 1'b0);
        check("lock_pkts", pkt_log.size(), 2);
        if (pkt_log.size() == 2) begin
            check("lock_first", pkt_log[0], 1);
            check("lock_second", pkt_log[1], 3);
        end

        // Backpressure pattern on a port 0 packet.
        do_reset();
        m_tready = 1'b0;
        push_pkt(0, 3, 8'hA1, 1'b0);
        tick();
        pat = 6'b101001;
        for (int i = 0; i < 6; i++) begin
            m_tready = pat[i];
            tick();
        end
        m_tready = 1'b1;
        drain("bp", 1'b0);
        check("bp_beats", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("bp_d0", out_log[0], 8'hA1);
            check("bp_d1", out_log[1], 8'hA2);
            check("bp_d2", out_log[2], 8'hA3);
        end

        // Single-beat packet occupies one active cycle.
        push_pkt(1, 1, 8'h5A, 1'b0);
        tick();
        check("one_grant", grant, 4'b0010);
        tick();
        check("one_idle", grant, 4'b0000);
        drain("one", 1'b0);

        // Reset on beat 2 of a 4-beat packet from port 3.
        do_reset();
        push_pkt(3, 4, 8'h31, 1'b0);
        tick();
        tick();
        areset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        refresh_src();
        tick();
        areset = 1'b0;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_s_tready", s_tready, 0);
        check("mid_rst_m_tvalid", m_tvalid, 0);
        check("mid_rst_m_tdata", m_tdata, 0);
        check("mid_rst_m_tlast", m_tlast, 0);
        check("mid_rst_m_tid", m_tid, 0);
        pkt_log.delete();
        push_pkt(0, 1, 8'h0F, 1'b0);
        push_pkt(3, 1, 8'h3F, 1'b0);
        tick();
        check("mid_rst_regrant", grant, 4'b0001);
        drain("mid_rst", 1'b0);

        // Random packets on three ports with random downstream backpressure.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            push_pkt(int'($urandom_range(0, 2)), int'($urandom_range(1, 5)), 8'h00, 1'b1);
        end
        drain("rand", 1'b1);
        check("rand_pkts", pkt_log.size(), 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_arb_mux.md
AXIS_ARB_MUX -- requirements
Module: axis_arb_mux

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8: tdata width in bits, multiple of 8.
- NUM_PORTS, default 4: number of slave streams, legal range 2..16.
- ID_WIDTH, default $clog2(NUM_PORTS): m_tid width.

REQ-002 Ports SHALL be:
- aclk  in  1  sole clock.
- areset  in  1  reset.
- s_tdata  in  NUM_PORTS*DATA_WIDTH  port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tkeep  in  NUM_PORTS*DATA_WIDTH/8  port i at bits [i*DATA_WIDTH/8 +: DATA_WIDTH/8].
- s_tvalid  in  NUM_PORTS  per-port valid.
- s_tready  out  NUM_PORTS  per-port ready.
- s_tlast  in  NUM_PORTS  per-port end of packet.
- m_tdata  out  DATA_WIDTH  merged data, feeds axis_fifo s_tdata.
- m_tkeep  out  DATA_WIDTH/8  merged keep.
- m_tvalid  out  1  merged valid.
- m_tready  in  1  merged ready, driven by axis_fifo s_tready.
- m_tlast  out  1  merged last.
- m_tid  out  ID_WIDTH  index of the source port of the current beat.
- grant  out  NUM_PORTS  one-hot owner; all zero in IDLE.

REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high, sampled on the rising edge of aclk.

Function
REQ-004 The FSM SHALL have two states, IDLE and ACTIVE.

REQ-005 IDLE with any s_tvalid high SHALL select a winner by round-robin, register grant and go to ACTIVE on the next edge; IDLE with no s_tvalid high SHALL stay in IDLE.

REQ-006 Round-robin search SHALL start at (last_grant+1) mod NUM_PORTS and proceed upward with wrap; last_grant SHALL update to the winner when ACTIVE is entered.

REQ-007 In ACTIVE, s_tready SHALL be high only for the granted port, and only when the output stage can accept a beat; all other s_tready bits SHALL be 0.

REQ-008 A beat SHALL be transferred when s_tvalid[g] and s_tready[g] are both high; the accepted fields SHALL be forwarded unmodified, with m_tid = g.

REQ-009 The grant SHALL remain locked to port g until a beat with s_tlast[g]=1 is accepted, and the FSM SHALL then return to IDLE on the next edge.

REQ-010 If s_tvalid[g] deasserts mid-packet, the grant SHALL be held and no other port SHALL be served.

REQ-011 Throughput SHALL be an L-beat packet in L+1 cycles with no stall: one arbitration cycle per packet.

REQ-012 A port requesting alone SHALL win every arbitration.

REQ-013 With all ports requesting continuously, packets SHALL be served in the order 0,1,...,NUM_PORTS-1,0,...

REQ-014 A 1-beat packet with tlast high SHALL complete in one ACTIVE cycle.

REQ-015 No beat SHALL be lost or duplicated under any m_tready pattern.

REQ-016 m_tvalid SHALL NOT depend combinationally on m_tready.

Reset
REQ-017 On areset the block SHALL go to IDLE, set last_grant=NUM_PORTS-1 (port 0 wins first) and clear the output stage.

REQ-018 After reset, grant, s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast and m_tid SHALL all be 0.

REQ-019 Reset asserted mid-packet SHALL abandon the packet and discard buffered beats; the upstream source is responsible for re-framing.

Configuration
REQ-020 The macro AXIS_ARB_MUX_OUT_REG_EN SHALL select the output stage.

REQ-021 With AXIS_ARB_MUX_OUT_REG_EN defined:
- m_* SHALL be driven from a 2-entry skid register.
- Input-to-output latency SHALL be 1 cycle.
- Full throughput SHALL be sustained under continuous m_tready.
- s_tready[g] SHALL depend only on registered state, not on m_tready.

REQ-022 Without AXIS_ARB_MUX_OUT_REG_EN:
- The output stage SHALL be a combinational pass-through: m_tvalid = s_tvalid[g] in ACTIVE, s_tready[g] = m_tready in ACTIVE.
- Latency SHALL be 0 cycles.
- m_* SHALL be 0 whenever not ACTIVE.

Verification
REQ-023 Reset, then s_tvalid=4'b0100 with a 3-beat packet, m_tready=1 -> grant=4'b0100 one cycle after request; 3 beats out with m_tid=2; last beat carries m_tlast=1; IDLE on the following cycle.

REQ-024 All 4 ports each send 2-beat packets back-to-back, m_tready=1 -> m_tid packet order 0,1,2,3,0; each packet occupies 3 cycles.

REQ-025 Port 1 mid-packet drops s_tvalid for 5 cycles while port 3 requests -> port 3 is never granted until port 1's tlast beat is accepted; port 3 then wins.

REQ-026 Port 0 packet with m_tready toggling 1,0,0,1,0,1 and tdata 0xA1,0xA2,0xA3 -> m_tdata sequence exactly 0xA1,0xA2,0xA3 with no loss or duplication; checked with and without AXIS_ARB_MUX_OUT_REG_EN.

REQ-027 Reset asserted on beat 2 of a 4-beat packet from port 3 -> next cycle all outputs are 0 and IDLE; the next request from ports {0,3} grants port 0.

REQ-028 Connect m_* to axis_fifo (ADDR_DEPTH=4, same clock on both sides), 3 ports streaming 40 random packets -> every packet is received intact, contiguous and with the correct m_tid, including while the FIFO is full.
